// File: rtl/uart_fifo_tx.sv
// -----------------------------------------------------------------------------
// uart_fifo_tx
// UART transmit engine: drains bytes from a FIFO read port and serialises each
// one as a start bit, DW data bits (LSB first) and STOP_BITS stop bits on o_tx.
// Each bit level is held for exactly CLK_DIV clocks.
//
// Ports
//   i_clk         clock, all logic on the rising edge
//   i_reset       synchronous active-high reset; aborts any frame in flight
//   i_fifo_dat    FIFO head-of-queue data (registered FIFO output)
//   i_fifo_empty  FIFO empty flag, only looked at in IDLE
//   o_fifo_pop    one-cycle pop strobe, high exactly while in LOAD
//   o_tx          registered serial line, idles high
//   o_busy        high whenever the engine is not in IDLE
// -----------------------------------------------------------------------------
module uart_fifo_tx #(
   parameter int unsigned CLK_DIV   = 16,
   parameter int unsigned DW        = 8,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [DW-1:0] i_fifo_dat,
   input  logic          i_fifo_empty,
   output logic          o_fifo_pop,
   output logic          o_tx,
   output logic          o_busy
);

   localparam int unsigned TMR_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IDX_W = $clog2(DW + 1);

   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DW - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   // Reject parameter values outside the legal range at elaboration time.
   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("uart_fifo_tx: CLK_DIV must be >= 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("uart_fifo_tx: STOP_BITS must be 1 or 2");
   end
   if (DW < 1) begin : g_bad_dw
      $error("uart_fifo_tx: DW must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic             tx_q,    tx_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [DW-1:0]    shreg_q, shreg_d;

   logic             bit_end;

   // Last clock of the current bit period.
   assign bit_end = (timer_q == TMR_LAST);

   // State and datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         tx_q    <= 1'b1;
         timer_q <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;

      // The bit timer free-runs inside a frame and wraps at each bit boundary.
      if ((state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP)) begin
         timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            tx_d    = 1'b1;
            timer_d = '0;
            idx_d   = '0;
            if (!i_fifo_empty) begin
               state_d = ST_LOAD;
            end
         end

         // Head-of-queue data is guaranteed valid here; capture it while
         // popping, and launch the start bit on the same edge.
         ST_LOAD: begin
            shreg_d = i_fifo_dat;
            tx_d    = 1'b0;
            timer_d = '0;
            idx_d   = '0;
            state_d = ST_START;
         end

         ST_START: begin
            if (bit_end) begin
               tx_d    = shreg_q[0];
               shreg_d = shreg_q >> 1;
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               if (idx_q == DATA_LAST) begin
                  tx_d    = 1'b1;
                  idx_d   = '0;
                  state_d = ST_STOP;
               end else begin
                  tx_d    = shreg_q[0];
                  shreg_d = shreg_q >> 1;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end

         // The bit index is reused to count stop bits.
         ST_STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (idx_q == STOP_LAST) begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         default: begin
            tx_d    = 1'b1;
            timer_d = '0;
            idx_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pop is a pure decode of LOAD so exactly one strobe accompanies each byte.
   assign o_fifo_pop = (state_q == ST_LOAD);
   assign o_busy     = (state_q != ST_IDLE);
   assign o_tx       = tx_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_tx
// Self-checking bench for uart_fifo_tx (CLK_DIV=4, DW=8). Two instances: one
// with one stop bit, one with two. Each is fed by a small registered FIFO model.
// -----------------------------------------------------------------------------
module tb_uart_fifo_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance 1 (STOP_BITS=1)
   logic       push1 = 1'b0;
   logic [7:0] push1_dat = 8'h00;
   logic [7:0] f1_dat;
   logic       f1_empty;
   logic       pop1, tx1, busy1;
   logic       pop1_s = 1'b0;
   logic [7:0] q1[$];
   logic [7:0] drop1;

   // Instance 2 (STOP_BITS=2)
   logic       push2 = 1'b0;
   logic [7:0] push2_dat = 8'h00;
   logic [7:0] f2_dat;
   logic       f2_empty;
   logic       pop2, tx2, busy2;
   logic       pop2_s = 1'b0;
   logic [7:0] q2[$];
   logic [7:0] drop2;

   int checks = 0;
   int errors = 0;
   int pop_cnt1 = 0;
   int pop_empty1 = 0;

   uart_fifo_tx #(.CLK_DIV(4), .DW(8), .STOP_BITS(1)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_fifo_dat  (f1_dat),
      .i_fifo_empty(f1_empty),
      .o_fifo_pop  (pop1),
      .o_tx        (tx1),
      .o_busy      (busy1)
   );

   uart_fifo_tx #(.CLK_DIV(4), .DW(8), .STOP_BITS(2)) dut2 (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_fifo_dat  (f2_dat),
      .i_fifo_empty(f2_empty),
      .o_fifo_pop  (pop2),
      .o_tx        (tx2),
      .o_busy      (busy2)
   );

   // Pop strobes are sampled mid-cycle so the FIFO models see the pre-edge value.
   always @(negedge clk) begin
      pop1_s = pop1;
      pop2_s = pop2;
      if (pop1 === 1'b1) pop_cnt1++;
      if ((pop1 === 1'b1) && (f1_empty === 1'b1)) pop_empty1++;
   end

   // Registered FIFO models: flag and head data update on the clock edge.
   always @(posedge clk) begin
      if (rst) begin
         q1.delete();
         f1_empty <= 1'b1;
         f1_dat   <= 8'h00;
      end else begin
         if (pop1_s && (q1.size() > 0)) drop1 = q1.pop_front();
         if (push1) q1.push_back(push1_dat);
         f1_empty <= (q1.size() == 0);
         f1_dat   <= (q1.size() > 0) ? q1[0] : 8'h00;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         q2.delete();
         f2_empty <= 1'b1;
         f2_dat   <= 8'h00;
      end else begin
         if (pop2_s && (q2.size() > 0)) drop2 = q2.pop_front();
         if (push2) q2.push_back(push2_dat);
         f2_empty <= (q2.size() == 0);
         f2_dat   <= (q2.size() > 0) ? q2[0] : 8'h00;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // exp_seq[k] is the k-th transmitted bit (start bit first).
   typedef struct {
      logic [7:0]  data;
      logic [10:0] exp_seq;
      int          nbits;
      int          which;
   } vec_t;

   // Push one byte at the edge following the current negedge, then watch 63
   // cycles. Index i = i-th negedge after the push edge.
   task automatic send_check(input vec_t v);
      int    frame_end, n_pop, first_pop, tx_bad, busy_bad, first_low, last_busy;
      logic  t, b, p, exp_t, exp_b;
      string nm;
      nm        = $sformatf("vec_%02h_s%0d", v.data, v.nbits - 9);
      frame_end = 3 + v.nbits * 4;
      n_pop = 0; first_pop = -1; tx_bad = 0; busy_bad = 0; first_low = -1; last_busy = -1;
      if (v.which == 0) begin push1 = 1'b1; push1_dat = v.data; end
      else              begin push2 = 1'b1; push2_dat = v.data; end
      for (int i = 1; i < 64; i++) begin
         @(negedge clk);
         push1 = 1'b0;
         push2 = 1'b0;
         t = (v.which == 0) ? tx1   : tx2;
         b = (v.which == 0) ? busy1 : busy2;
         p = (v.which == 0) ? pop1  : pop2;
         exp_t = ((i >= 3) && (i < frame_end)) ? v.exp_seq[(i - 3) / 4] : 1'b1;
         exp_b = (i >= 2) && (i < frame_end);
         if (t !== exp_t) tx_bad++;
         if (b !== exp_b) busy_bad++;
         if (p === 1'b1) begin
            n_pop++;
            if (first_pop < 0) first_pop = i;
         end
         if ((t === 1'b0) && (first_low < 0)) first_low = i;
         if (b === 1'b1) last_busy = i;
      end
      chk({nm, "_pop_count"}, n_pop, 1);
      chk({nm, "_pop_cycle"}, first_pop, 2);
      chk({nm, "_tx_bad_cycles"}, tx_bad, 0);
      chk({nm, "_busy_bad_cycles"}, busy_bad, 0);
      chk({nm, "_frame_len"}, last_busy - first_low + 1, v.nbits * 4);
   endtask

   // Decode one frame from tx1 starting at a negedge. status: 0 ok, 1 bad
   // stop bit, 2 timeout. hi_run counts high cycles seen before the start bit.
   task automatic decode_frame(output logic [7:0] d, output int hi_run, output int status);
      d = 8'h00; hi_run = 0; status = 0;
      while (tx1 !== 1'b0) begin
         if (hi_run >= 3000) begin
            status = 2;
            return;
         end
         @(negedge clk);
         hi_run++;
      end
      repeat (5) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         d[b] = tx1;
         if (b < 7) repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      if (tx1 !== 1'b1) status = 1;
      repeat (3) @(negedge clk);
   endtask

   // Safety net against a hung run.
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   vec_t vecs[4];

   initial begin
      logic [7:0] d, e;
      int         hr, st, base, bad, rx_bad, frame_bad;
      logic [7:0] sb[$];

      vecs[0] = '{8'hA5, 11'b0_1101001010, 10, 0};
      vecs[1] = '{8'h3C, 11'b0_1001111000, 10, 0};
      vecs[2] = '{8'h00, 11'b0_1000000000, 10, 0};
      vecs[3] = '{8'hC3, 11'b11110000110, 11, 1};

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_tx", tx1, 1);
      chk("reset_busy", busy1, 0);
      chk("reset_pop", pop1, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single-frame vectors (including the two-stop-bit instance)
      for (int k = 0; k < 4; k++) begin
         send_check(vecs[k]);
      end

      // Back-to-back pushes of 0x00, 0xFF, 0x3C
      base = pop_cnt1;
      push1 = 1'b1; push1_dat = 8'h00;
      @(negedge clk); push1_dat = 8'hFF;
      @(negedge clk); push1_dat = 8'h3C;
      @(negedge clk); push1 = 1'b0;
      decode_frame(d, hr, st);
      chk("b2b_f0_status", st, 0);
      chk("b2b_f0_data", int'(d), 'h00);
      decode_frame(d, hr, st);
      chk("b2b_f1_status", st, 0);
      chk("b2b_f1_data", int'(d), 'hFF);
      chk("b2b_f1_gap", hr, 2);
      decode_frame(d, hr, st);
      chk("b2b_f2_status", st, 0);
      chk("b2b_f2_data", int'(d), 'h3C);
      chk("b2b_f2_gap", hr, 2);
      repeat (4) @(negedge clk);
      chk("b2b_pops", pop_cnt1 - base, 3);
      chk("b2b_fifo_empty", f1_empty, 1);

      // Long idle with an empty FIFO
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((tx1 !== 1'b1) || (busy1 !== 1'b0) || (pop1 !== 1'b0)) bad++;
      end
      chk("idle_bad_cycles", bad, 0);

      // Reset during data bit 3 of 0x5A
      base = pop_cnt1;
      push1 = 1'b1; push1_dat = 8'h5A;
      @(negedge clk); push1 = 1'b0;
      repeat (19) @(negedge clk);
      chk("abort_busy_before", busy1, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx", tx1, 1);
      chk("abort_busy", busy1, 0);
      chk("abort_pop", pop1, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_pops", pop_cnt1 - base, 1);
      chk("abort_idle_busy", busy1, 0);
      send_check('{8'h81, 11'b0_1100000010, 10, 0});

      // 500 random bytes with random push timing
      base = pop_cnt1;
      rx_bad = 0;
      frame_bad = 0;
      fork
         begin
            for (int i = 0; i < 500; i++) begin
               repeat ($urandom_range(0, 60)) @(negedge clk);
               push1_dat = 8'($urandom);
               push1 = 1'b1;
               sb.push_back(push1_dat);
               @(negedge clk);
               push1 = 1'b0;
            end
         end
         begin
            for (int i = 0; i < 500; i++) begin
               decode_frame(d, hr, st);
               if (st == 2) begin
                  frame_bad++;
                  break;
               end
               if (st != 0) frame_bad++;
               if (sb.size() == 0) begin
                  rx_bad++;
               end else begin
                  e = sb.pop_front();
                  if (e !== d) rx_bad++;
               end
            end
         end
      join
      repeat (10) @(negedge clk);
      chk("rand_data_mismatches", rx_bad, 0);
      chk("rand_frame_errors", frame_bad, 0);
      chk("rand_pops", pop_cnt1 - base, 500);
      chk("rand_scoreboard_left", sb.size(), 0);
      chk("pop_while_empty", pop_empty1, 0);
      chk("rand_fifo_empty", f1_empty, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
